mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the core's `io_*` load/store request interface. Accepts one request at a time from the load/store unit, performs a byte-masked word write or a full-word read on an internal word-addressed array, and returns a single-cycle `io_respValid` pulse after a fixed latency. It sits between the LSU and on-chip data memory, and also serves as the reference memory model in unit benches.

## Interface
- `DEPTH_WORDS`, 1024: array depth in 32-bit words, power of two.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0, aligned to `DEPTH_WORDS*4`.
- `LATENCY`, 2: cycles from request accept to `io_respValid`, minimum 1.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned for out-of-range reads.

Ports:
- `clock` in 1: sole clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `io_reqValid` in 1: request strobe; a one-cycle pulse per request.
- `io_addr` in 32: byte address; bits [1:0] ignored.
- `io_wen` in 1: 1 = write, 0 = read.
- `io_wdata` in 32: write data, already lane-aligned by the initiator.
- `io_wmask` in 4: byte-lane enables for writes.
- `io_size` in 2: 00 byte, 01 half, 10 word, 11 extended. Latched for debug only; it does not affect the access.
- `io_respValid` out 1: one-cycle completion pulse.
- `io_rdata` out 32: read word, valid only while `io_respValid` is high.
- `io_err` out 1: out-of-range flag, valid only while `io_respValid` is high.

## Operation
- FSM states are `IDLE`, `BUSY`, `RESP`.
- **IDLE**
  - If `io_reqValid` is high: latch address, wen, wdata, wmask and size into request registers, and load the delay counter with `LATENCY-1`.
  - If that counter value is 0, go to `RESP`; otherwise go to `BUSY`.
- **BUSY**: decrement the counter; when it reaches 0, go to `RESP`.
- **RESP**: assert `io_respValid`, then return to `IDLE`.
- `io_reqValid` asserted in `BUSY` or `RESP` is ignored. The initiator never issues a request while one is outstanding.
- **Range check**: `in_range` = (`io_addr` − `BASE_ADDR`) < `DEPTH_WORDS*4`, using unsigned 32-bit wrap-around. Word index = (`io_addr` − `BASE_ADDR`)[log2(`DEPTH_WORDS`)+1:2].
- **Write**
  - Commits at the clock edge that accepts the request: every lane i with `io_wmask[i]` set is written from `io_wdata[8i+7:8i]`.
  - `io_wmask` = 0000 writes nothing but still completes normally.
  - An out-of-range write is dropped; `io_err` = 1 at response.
- **Read**
  - Array read is issued from the latched index one cycle before `RESP`, so `io_rdata` is valid in `RESP`.
  - An out-of-range read returns `ERR_RDATA` with `io_err` = 1.
  - Reads always return the full word; alignment and sign extension are the initiator's job.
- Outside `RESP`, `io_rdata` and `io_err` hold their previous values. They are not forced to zero.

## Timing
- Request accepted in cycle T, so `io_respValid` is high in cycle T+`LATENCY`, for exactly one cycle.
- A new request may be accepted in cycle T+`LATENCY`+1, the cycle after `RESP`. This supports the initiator's misaligned two-part sequence: response, a one-cycle gap, then the second request.
- Read-after-write to the same word in back-to-back requests returns the written data.
- **Reset values**: `io_respValid` 0, `io_rdata` 0, `io_err` 0, FSM `IDLE`, counter 0.
- **Reset mid-operation**: the pending request is dropped and no response is issued. A write that was already accepted stays committed. Array contents are not reset.

## Configuration
- `MEM_RESP_JITTER_EN` defined:
  - An 8-bit LFSR (polynomial x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances every cycle.
  - At accept, `lfsr[1:0]` is added to the loaded counter, giving latency `LATENCY`..`LATENCY`+3.
  - All other behaviour is unchanged.
- Undefined: latency is exactly `LATENCY`, and no LFSR logic exists.

## Structure
- Shared package `soc_mem_pkg`:
  - size localparams `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`/`MEM_EXTA`;
  - typedef enum `mem_resp_state` {`IDLE`, `BUSY`, `RESP`}.
- Sub-module `sram_1r1w_be`:
  - synchronous 1-read/1-write word array, `DEPTH_WORDS` deep;
  - per-byte write enables;
  - registered read port;
  - no reset on contents.
- `mem_responder` owns the FSM, the counter, the range check, the request registers and the optional LFSR.

## Test plan
- **Reset**: hold `reset_n`=0, then release. `io_respValid`, `io_rdata` and `io_err` are 0; the first request completes in exactly `LATENCY` cycles.
- **Word write/read**: write 32'h1234_5678, mask 1111, to 8000_0010; then read 8000_0010. The read returns 32'h1234_5678 with `io_err`=0; `io_respValid` arrives at T+2 for each request.
- **Byte lanes**: write 32'hFFFF_FFFF mask 1111 to 8000_0020; then write 32'h00AB_0000 mask 0100; then read. The read returns 32'hFFAB_FFFF.
- **Misaligned pair**:
  - Issue a write with mask 1000 to 8000_0003, response, one-cycle gap, then a write with mask 0111 to 8000_0004.
  - Both are accepted with no lost request.
  - Reading back the two words shows only the masked bytes changed.
- **Out of range**: read 7FFF_FFFC → `io_rdata`=DEAD_BEEF, `io_err`=1. Write 8000_1000 (DEPTH 1024) → no array change, `io_err`=1.
- **Reset mid-op**: assert `reset_n`=0 in `BUSY` after a read request. No `io_respValid` appears; after release, a new request completes normally.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared size codes, responder FSM states and request record
package soc_mem_pkg;
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_EXTA = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_resp_state;
    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  size;
    } mem_req_t;
endpackage

// File: rtl/sram_1r1w_be.sv
// sram_1r1w_be: word array with per-byte write enables and a registered read port
module sram_1r1w_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    // byte-lane write; contents are never reset
    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int i = 0; i < 4; i++)
                if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    // registered read, data appears the cycle after re_i
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder; MEM_RESP_JITTER_EN adds 0..3 cycles of LFSR latency jitter
module mem_responder
    import soc_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_reqValid,
    input  logic [31:0] io_addr,
    input  logic        io_wen,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wmask,
    input  logic [1:0]  io_size,
    output logic        io_respValid,
    output logic [31:0] io_rdata,
    output logic        io_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 3) + 1;
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    mem_resp_state state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_ld;
    mem_req_t      req_q, req_d;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   off_in, off_req, sram_rdata;
    logic          inr_in, inr_req, accept, rd_wen;
    logic [AW-1:0] raddr;
    assign off_in  = io_addr - BASE_ADDR;
    assign off_req = req_q.addr - BASE_ADDR;
    assign inr_in  = off_in < SPAN;
    assign inr_req = off_req < SPAN;
    assign accept  = state_q == IDLE && io_reqValid;
`ifdef MEM_RESP_JITTER_EN
    logic [7:0] lfsr_q;
    // free-running x^8+x^6+x^5+x^4+1 LFSR supplying latency jitter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 8'hA5;
        else lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign cnt_ld = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
    assign cnt_ld = CW'(LATENCY - 1);
`endif
    // in IDLE the array read must use the live request so LATENCY=1 still works
    assign raddr  = state_q == IDLE ? off_in[AW+1:2] : off_req[AW+1:2];
    assign rd_wen = state_q == IDLE ? io_wen : req_q.wen;
    assign io_respValid = state_q == RESP;
    assign io_rdata = io_respValid ? (inr_req ? sram_rdata : ERR_RDATA) : rdata_q;
    assign io_err   = io_respValid ? !inr_req : err_q;
    sram_1r1w_be #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
        .clk_i   (clock),
        .we_i    (accept && io_wen && inr_in),
        .waddr_i (off_in[AW+1:2]),
        .wdata_i (io_wdata),
        .be_i    (io_wmask),
        .re_i    (state_d == RESP && !rd_wen),
        .raddr_i (raddr),
        .rdata_o (sram_rdata)
    );
    // next-state: accept, count down the latency, then pulse the response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: if (io_reqValid) begin
                req_d   = '{addr: io_addr, wen: io_wen, wdata: io_wdata, wmask: io_wmask, size: io_size};
                cnt_d   = cnt_ld;
                state_d = cnt_ld == '0 ? RESP : BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CW'(1) ? RESP : BUSY;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state, counter, request registers and held response outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            if (io_respValid) begin
                rdata_q <= io_rdata;
                err_q   <= io_err;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (default build, LATENCY=2)
module tb_mem_responder;
    localparam int LAT = 2;
    typedef struct {
        string       tag;
        logic        rd;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    logic        clk = 0, reset_n = 0;
    logic        io_reqValid = 0, io_wen = 0;
    logic [31:0] io_addr = 0, io_wdata = 0;
    logic [3:0]  io_wmask = 0;
    logic [1:0]  io_size = 0;
    logic        io_respValid, io_err;
    logic [31:0] io_rdata;
    int          nvec = 0, nmis = 0, cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [1024];

    mem_responder dut (
        .clock(clk), .reset_n(reset_n), .io_reqValid(io_reqValid), .io_addr(io_addr),
        .io_wen(io_wen), .io_wdata(io_wdata), .io_wmask(io_wmask), .io_size(io_size),
        .io_respValid(io_respValid), .io_rdata(io_rdata), .io_err(io_err)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && io_respValid) begin
            if (sb.size() == 0) chk("spurious_resp", 1, 0);
            else begin
                mon_e = sb.pop_front();
`ifdef MEM_RESP_JITTER_EN
                chk({mon_e.tag, "_lat"}, 32'(cyc >= mon_e.cyc && cyc <= mon_e.cyc + 3), 1);
`else
                chk({mon_e.tag, "_lat"}, cyc, mon_e.cyc);
`endif
                if (mon_e.rd) chk({mon_e.tag, "_rdata"}, io_rdata, mon_e.rdata);
                chk({mon_e.tag, "_err"}, io_err, mon_e.err);
            end
        end
    end

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic req(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        logic [31:0] off;
        off = a - 32'h8000_0000;
        @(negedge clk);
        io_reqValid = 1; io_addr = a; io_wen = w; io_wdata = d; io_wmask = m; io_size = 2'b10;
        e.tag = tag;
        e.rd = !w;
        e.err = !(off < 32'h1000);
        e.cyc = cyc + LAT;
        e.rdata = e.err ? 32'hDEAD_BEEF : ref_mem[off[11:2]];
        if (w && !e.err)
            for (int i = 0; i < 4; i++)
                if (m[i]) ref_mem[off[11:2]][8*i +: 8] = d[8*i +: 8];
        sb.push_back(e);
        @(negedge clk);
        io_reqValid = 0;
        wait_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", io_respValid, 0);
        chk("rst_rdata", io_rdata, 0);
        chk("rst_err", io_err, 0);
        reset_n = 1;
        @(negedge clk);
        chk("post_rst_valid", io_respValid, 0);
        chk("post_rst_rdata", io_rdata, 0);
        req("word_wr", 32'h8000_0010, 1, 32'h1234_5678, 4'b1111);
        req("word_rd", 32'h8000_0010, 0, 0, 4'b0000);
        req("lane_wr0", 32'h8000_0020, 1, 32'hFFFF_FFFF, 4'b1111);
        req("lane_wr1", 32'h8000_0020, 1, 32'h00AB_0000, 4'b0100);
        req("lane_rd", 32'h8000_0020, 0, 0, 4'b0000);
        chk("lane_model", ref_mem[8], 32'hFFAB_FFFF);
        req("mis_init0", 32'h8000_0000, 1, 32'h1122_3344, 4'b1111);
        req("mis_init1", 32'h8000_0004, 1, 32'h5566_7788, 4'b1111);
        req("mis_hi", 32'h8000_0003, 1, 32'hAA00_0000, 4'b1000);
        req("mis_lo", 32'h8000_0004, 1, 32'h00BB_CCDD, 4'b0111);
        req("mis_rd0", 32'h8000_0000, 0, 0, 4'b0000);
        req("mis_rd1", 32'h8000_0004, 0, 0, 4'b0000);
        req("oor_rd", 32'h7FFF_FFFC, 0, 0, 4'b0000);
        req("oor_wr", 32'h8000_1000, 1, 32'h0BAD_0BAD, 4'b1111);
        req("oor_chk", 32'h8000_0000, 0, 0, 4'b0000);
        req("nomask_wr", 32'h8000_0010, 1, 32'h0000_0000, 4'b0000);
        req("nomask_rd", 32'h8000_0010, 0, 0, 4'b0000);
        req("top_wr", 32'h8000_0FFC, 1, 32'hCAFE_F00D, 4'b1111);
        req("top_rd", 32'h8000_0FFC, 0, 0, 4'b0000);
        for (int i = 0; i < 8; i++)
            req("rnd_init", 32'h8000_0100 + 32'(i * 4), 1, $urandom, 4'b1111);
        for (int i = 0; i < 24; i++)
            req("rnd", 32'h8000_0100 + (32'($urandom_range(0, 7)) << 2),
                1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        @(negedge clk);
        io_reqValid = 1; io_addr = 32'h8000_0010; io_wen = 0;
        @(negedge clk);
        io_reqValid = 0;
        #2 reset_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_valid", io_respValid, 0);
        end
        chk("midrst_rdata", io_rdata, 0);
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_idle", io_respValid, 0);
        end
        req("after_rst_rd", 32'h8000_0010, 0, 0, 4'b0000);
        req("after_rst_rd2", 32'h8000_0FFC, 0, 0, 4'b0000);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
